demux_stream_scheduler: RTL and testbench
=========================================

Name: demux_stream_scheduler

Overview:
- Packet-level scheduler that shares one input stream across 4 downstream channels through a 1-to-4 demux.
- Picks a destination per packet by round-robin among enabled channels that hold credit, then locks the demux select until the packet's last beat.
- Drives the demux `sel` and per-channel valid/ready steering.
- Tracks per-channel credits returned by the sinks.

Parameters:
- DATA_W, 8, width of the data beat.
- CREDITS, 4, initial and maximum credits per channel (packets in flight per sink); must be ≥1.
- CNT_W, $clog2(CREDITS+1), width of each credit counter (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- chan_en  input  4  per-channel enable (configuration); bit i=0 excludes channel i from arbitration.
- in_valid  input  1  upstream beat valid.
- in_data  input  DATA_W  upstream beat data.
- in_last  input  1  final beat of packet.
- in_ready  output  1  upstream beat accepted when in_valid&in_ready.
- out_valid  output  4  one-hot beat valid to channel i.
- out_data  output  DATA_W  beat data, broadcast to all channels.
- out_last  output  1  copy of in_last.
- out_ready  input  4  per-channel sink ready.
- credit_ret  input  4  per-channel one-cycle credit-return pulse (one packet freed).
- sel  output  2  demux select / current channel.
- busy  output  1  high while a packet is locked to a channel.
- credit_cnt  output  4*CNT_W  packed credit counters, channel i at [i*CNT_W +: CNT_W].
- credit_err  output  1  sticky: credit returned to a full counter.

Behaviour:
- Reset (rst_n=0 at a clk edge), all synchronous, any state including mid-packet:
  - state=IDLE, sel=0, rr pointer=3 (so channel 0 wins first), busy=0, in_ready=0, out_valid=0.
  - credit counters=CREDITS, credit_err=0.
  - A partially forwarded packet is abandoned.
- States: IDLE, XFER.
- IDLE:
  - in_ready=0, out_valid=0.
  - If in_valid=1 and at least one channel is eligible (chan_en[i]=1 and credit[i]>0): grant the first eligible channel searching from pointer+1 upward (mod 4).
  - On grant, next cycle: sel=grant, rr pointer=grant, state=XFER.
  - Otherwise stay in IDLE. The upstream is stalled and no beat is lost.
- XFER:
  - Combinational: out_valid[sel]=in_valid; other bits 0. in_ready=out_ready[sel]. out_data=in_data, out_last=in_last.
  - Beat transfers when in_valid&out_ready[sel].
  - A transfer with in_last=1 decrements credit[sel] in that cycle and returns the FSM to IDLE next cycle.
  - Otherwise stay in XFER.
  - sel and pointer stay stable for the whole packet. chan_en changes do not affect the packet in flight.
- Latency:
  - First beat of a packet is accepted no earlier than 1 cycle after in_valid rises in IDLE.
  - Back-to-back packets incur one IDLE bubble cycle.
  - Beats within a packet pass at full throughput with zero latency.
- busy = (state==XFER).
- Credits:
  - credit_ret[i] increments credit[i].
  - Simultaneous return and consume on the same channel: net unchanged.
  - Return while credit[i]==CREDITS with no consume: counter holds at CREDITS and credit_err sets, cleared only by reset.
  - Consume never occurs at 0, because grant requires credit>0 and one packet consumes exactly one credit.
- Single-beat packet (in_last on first beat) is legal: one cycle in XFER.
- All channels ineligible: IDLE indefinitely with in_ready=0. Resumes the cycle after any credit return or enable makes a channel eligible.
- out_data and out_last are valid only when some out_valid bit is high. Otherwise out_data/out_last = in_data/in_last (don't-care).

Decomposition:
- Package demux_sched_pkg:
  - NUM_CH=4, SEL_W=2.
  - state_t enum {IDLE, XFER}.
  - sel_t = logic [SEL_W-1:0].
- Sub-module rr_arbiter_4:
  - Inputs: req[3:0] (eligible mask), ptr sel_t.
  - Outputs: gnt_valid, gnt sel_t.
  - Purely combinational rotate-priority search.
- The FSM, pointer and credit counters stay in demux_stream_scheduler.

Test Plan:
- Reset, all chan_en=1, out_ready=4'hF, four 2-beat packets back-to-back → sel sequence 0,1,2,3; out_valid one-hot matches sel; each credit_cnt drops 4→3; one in_ready=0 bubble between packets.
- chan_en=4'b1010, three 1-beat packets → destinations 1,3,1; credit[1]=2, credit[3]=3; channels 0 and 2 never see out_valid.
- CREDITS=4, only channel 2 enabled, send 5 packets with no credit_ret → first 4 go to ch2 (credit 0); 5th stalls in IDLE with in_ready=0. Pulse credit_ret[2] → 5th forwarded; credit[2] ends 0.
- During a 4-beat packet on ch0, drop out_ready[0] for 3 cycles mid-packet and toggle chan_en[0]=0 → in_ready=0 for exactly those cycles, no beat lost or duplicated, sel stays 0 until last beat.
- credit_ret[1] on the same cycle ch1 accepts in_last → credit[1] unchanged. Then credit_ret[3] with credit[3]=4 → credit[3] stays 4, credit_err=1.
- Assert rst_n=0 for one cycle during beat 2 of a 3-beat packet → next cycle busy=0, sel=0, all credits=4, credit_err=0, out_valid=0; next packet goes to ch0.

Source files
------------

// File: rtl/demux_stream_scheduler_pkg.sv
// Shared types and constants for the 4-channel packet demux scheduler.
// Holds the channel count, the select width, the FSM state type and a one-hot helper.
package demux_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_CH-1:0] onehot(input sel_t s);
    return NUM_CH'(1) << s;
  endfunction

endpackage

// File: rtl/demux_stream_scheduler_if.sv
// Stream bundle between the upstream source, the scheduler and the four sinks.
// The master modport is the testbench side; the slave modport is the scheduler side.
interface demux_stream_scheduler_if #(
  parameter int DATA_W = 8
);
  import demux_sched_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic [NUM_CH-1:0] out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [NUM_CH-1:0] out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/demux_stream_scheduler_rr_arbiter.sv
// Combinational round-robin search over four requesters.
// Priority starts at the channel just after ptr and wraps modulo four.
module rr_arbiter_4
  import demux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic              gnt_valid,
  output sel_t              gnt
);

  sel_t w_idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = ptr + sel_t'(k);
      if (!gnt_valid && req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt       = w_idx;
      end
    end
  end

endmodule

// File: rtl/demux_stream_scheduler.sv
// Packet scheduler: grants one enabled channel with credit per packet, round-robin,
// and holds the demux select until the last beat; tracks per-channel sink credits.
module demux_stream_scheduler
  import demux_sched_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int CREDITS = 4,
  localparam int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       chan_en,
  input  logic [NUM_CH-1:0]       credit_ret,
  demux_stream_scheduler_if.slave s_if,
  output sel_t                    sel,
  output logic                    busy,
  output logic [NUM_CH*CNT_W-1:0] credit_cnt,
  output logic                    credit_err
);

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  state_t            r_state;
  state_t            w_state_nxt;
  sel_t              r_sel;
  sel_t              r_ptr;
  logic [CNT_W-1:0]  r_credit [NUM_CH];
  logic              r_credit_err;

  logic [NUM_CH-1:0] w_req;
  logic              w_gnt_valid;
  sel_t              w_gnt;
  logic              w_grant;
  logic              w_done;
  logic [NUM_CH-1:0] w_cons;
  logic [DATA_W-1:0] w_data;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign w_req[i] = chan_en[i] && (r_credit[i] != '0);
    assign credit_cnt[i*CNT_W +: CNT_W] = r_credit[i];
  end

  rr_arbiter_4 u_arb (
    .req       (w_req),
    .ptr       (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt       (w_gnt)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_grant        = 1'b0;
    w_done         = 1'b0;
    s_if.in_ready  = 1'b0;
    s_if.out_valid = '0;
    unique case (r_state)
      IDLE: begin
        if (s_if.in_valid && w_gnt_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        s_if.out_valid = s_if.in_valid ? onehot(r_sel) : '0;
        s_if.in_ready  = s_if.out_ready[r_sel];
        w_done         = s_if.in_valid && s_if.out_ready[r_sel] && s_if.in_last;
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cons        = w_done ? onehot(r_sel) : '0;
  assign w_data        = s_if.in_data;
  assign s_if.out_data = w_data;
  assign s_if.out_last = s_if.in_last;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_ptr        <= sel_t'(NUM_CH - 1);
      r_credit_err <= 1'b0;
      // NOTE: the credit array is a handful of flops, not a RAM, so it is reset like any other register.
      for (int i = 0; i < NUM_CH; i++) r_credit[i] <= CRED_MAX;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_sel <= w_gnt;
        r_ptr <= w_gnt;
      end
      // A return and a consume on the same channel cancel out.
      for (int i = 0; i < NUM_CH; i++) begin
        unique case ({credit_ret[i], w_cons[i]})
          2'b10: begin
            if (r_credit[i] == CRED_MAX) r_credit_err <= 1'b1;
            else                         r_credit[i]  <= r_credit[i] + 1'b1;
          end
          2'b01:   r_credit[i] <= r_credit[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign sel        = r_sel;
  assign busy       = (r_state == XFER);
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_demux_stream_scheduler.sv
// Self-checking bench: directed scenarios plus a random phase, all checked every
// cycle against a packet-level behavioural model of the scheduler.
module tb_demux_stream_scheduler;
  import demux_sched_pkg::*;

  localparam int DATA_W  = 8;
  localparam int CREDITS = 4;
  localparam int CNT_W   = $clog2(CREDITS + 1);

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [3:0]              chan_en;
  logic [3:0]              credit_ret;
  sel_t                    sel;
  logic                    busy;
  logic [4*CNT_W-1:0]      credit_cnt;
  logic                    credit_err;

  demux_stream_scheduler_if #(.DATA_W(DATA_W)) s_if ();

  demux_stream_scheduler #(.DATA_W(DATA_W), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chan_en    (chan_en),
    .credit_ret (credit_ret),
    .s_if       (s_if),
    .sel        (sel),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycles = 0;
  int delivered[4];

  // Reference model: packet lock, destination, round-robin pointer, credits.
  bit m_live = 1'b0;
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cred[4];
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*CNT_W-1:0] exp_cnt();
    logic [4*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cred[i]);
    return v;
  endfunction

  function automatic int cred_of(input int ch);
    return int'(credit_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic model_update();
    bit done;
    bit cons;
    int g;
    if (!rst_n) begin
      m_live = 1'b1;
      m_busy = 1'b0;
      m_sel  = 0;
      m_ptr  = 3;
      m_err  = 1'b0;
      for (int i = 0; i < 4; i++) m_cred[i] = CREDITS;
    end else if (m_live) begin
      done = m_busy && s_if.in_valid && s_if.out_ready[m_sel] && s_if.in_last;
      if (!m_busy) begin
        g = -1;
        if (s_if.in_valid)
          for (int k = 1; k <= 4; k++)
            if (g < 0 && chan_en[(m_ptr + k) % 4] && m_cred[(m_ptr + k) % 4] > 0) g = (m_ptr + k) % 4;
        if (g >= 0) begin
          m_busy = 1'b1;
          m_sel  = g;
          m_ptr  = g;
        end
      end else if (done) begin
        m_busy = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        cons = done && (m_sel == i);
        if (credit_ret[i] && !cons) begin
          if (m_cred[i] == CREDITS) m_err = 1'b1;
          else                      m_cred[i]++;
        end else if (cons && !credit_ret[i]) begin
          m_cred[i]--;
        end
      end
    end
  endtask

  // One clock: compare outputs on the falling edge, advance the model on the rising edge.
  task automatic step();
    logic       exp_rdy;
    logic [3:0] exp_ov;
    @(negedge clk);
    if (m_live) begin
      exp_rdy = m_busy && s_if.out_ready[m_sel];
      exp_ov  = (m_busy && s_if.in_valid) ? 4'(1 << m_sel) : 4'h0;
      check("in_ready",   s_if.in_ready,  exp_rdy);
      check("out_valid",  s_if.out_valid, exp_ov);
      check("busy",       busy,           m_busy);
      check("sel",        sel,            m_sel);
      check("credit_cnt", credit_cnt,     exp_cnt());
      check("credit_err", credit_err,     m_err);
      if (exp_ov != 4'h0) begin
        check("out_data", s_if.out_data, s_if.in_data);
        check("out_last", s_if.out_last, s_if.in_last);
      end
      for (int i = 0; i < 4; i++)
        if (s_if.out_valid[i] && s_if.out_ready[i]) delivered[i]++;
    end
    @(posedge clk);
    model_update();
    n_cycles++;
    #1;
  endtask

  // Present one beat and hold it until the model says it is taken; ret is pulsed on that cycle.
  task automatic accept_beat(input logic [7:0] data, input logic last, input logic [3:0] ret);
    bit acc;
    s_if.in_valid = 1'b1;
    s_if.in_data  = data;
    s_if.in_last  = last;
    for (int n = 0; n < 200; n++) begin
      acc = m_busy && s_if.out_ready[m_sel];
      if (acc) credit_ret = ret;
      step();
      credit_ret = 4'h0;
      if (acc) return;
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
    credit_ret    = 4'h0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) delivered[i] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    rst_n          = 1'b0;
    chan_en        = 4'hF;
    credit_ret     = 4'h0;
    s_if.in_valid  = 1'b0;
    s_if.in_data   = '0;
    s_if.in_last   = 1'b0;
    s_if.out_ready = 4'hF;
    repeat (2) step();

    // Reset state and four back-to-back 2-beat packets.
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_ready", s_if.in_ready, 0);
    check("rst_cnt", credit_cnt, {4{CNT_W'(CREDITS)}});
    check("rst_err", credit_err, 0);
    c0 = n_cycles;
    for (int p = 0; p < 4; p++) begin
      accept_beat(8'(8'h10 + 2*p), 1'b0, 4'h0);
      accept_beat(8'(8'h11 + 2*p), 1'b1, 4'h0);
      check("s1_sel", sel, p);
    end
    check("s1_cycles", n_cycles - c0, 12);
    for (int i = 0; i < 4; i++) check("s1_cred", cred_of(i), 3);
    s_if.in_valid = 1'b0;

    // Only channels 1 and 3 enabled.
    do_reset();
    chan_en = 4'b1010;
    accept_beat(8'hA1, 1'b1, 4'h0); check("s2_sel0", sel, 1);
    accept_beat(8'hA2, 1'b1, 4'h0); check("s2_sel1", sel, 3);
    accept_beat(8'hA3, 1'b1, 4'h0); check("s2_sel2", sel, 1);
    check("s2_cred1", cred_of(1), 2);
    check("s2_cred3", cred_of(3), 3);
    check("s2_ch0_idle", delivered[0], 0);
    check("s2_ch2_idle", delivered[2], 0);
    s_if.in_valid = 1'b0;

    // Credit exhaustion on channel 2, then recovery by a single return.
    do_reset();
    chan_en = 4'b0100;
    for (int p = 0; p < 4; p++) accept_beat(8'(8'hB0 + p), 1'b1, 4'h0);
    check("s3_cred_empty", cred_of(2), 0);
    s_if.in_valid = 1'b1;
    s_if.in_data  = 8'hB4;
    s_if.in_last  = 1'b1;
    repeat (4) begin
      step();
      check("s3_stall_ready", s_if.in_ready, 0);
      check("s3_stall_busy", busy, 0);
    end
    credit_ret = 4'b0100;
    step();
    credit_ret = 4'h0;
    accept_beat(8'hB4, 1'b1, 4'h0);
    check("s3_delivered", delivered[2], 5);
    check("s3_cred_end", cred_of(2), 0);
    s_if.in_valid = 1'b0;

    // Sink backpressure and enable change in the middle of a packet.
    do_reset();
    chan_en = 4'hF;
    accept_beat(8'hC0, 1'b0, 4'h0);
    accept_beat(8'hC1, 1'b0, 4'h0);
    s_if.in_data   = 8'hC2;
    s_if.out_ready = 4'hE;
    chan_en        = 4'hE;
    repeat (3) begin
      step();
      check("s4_hold_ready", s_if.in_ready, 0);
      check("s4_hold_sel", sel, 0);
    end
    s_if.out_ready = 4'hF;
    accept_beat(8'hC2, 1'b0, 4'h0);
    accept_beat(8'hC3, 1'b1, 4'h0);
    check("s4_beats", delivered[0], 4);
    check("s4_sel", sel, 0);
    check("s4_cred0", cred_of(0), 3);
    s_if.in_valid = 1'b0;
    chan_en       = 4'hF;

    // Return coinciding with consume, then a return into a full counter.
    do_reset();
    chan_en = 4'b0010;
    accept_beat(8'hD0, 1'b1, 4'b0010);
    check("s5_cred1", cred_of(1), 4);
    check("s5_no_err", credit_err, 0);
    s_if.in_valid = 1'b0;
    credit_ret    = 4'b1000;
    step();
    credit_ret = 4'h0;
    step();
    check("s5_cred3", cred_of(3), 4);
    check("s5_err", credit_err, 1);

    // Reset in the middle of a 3-beat packet.
    do_reset();
    chan_en = 4'hF;
    accept_beat(8'hE0, 1'b0, 4'h0);
    s_if.in_data = 8'hE1;
    rst_n        = 1'b0;
    step();
    rst_n = 1'b1;
    check("s6_busy", busy, 0);
    check("s6_sel", sel, 0);
    check("s6_cnt", credit_cnt, {4{CNT_W'(CREDITS)}});
    check("s6_err", credit_err, 0);
    check("s6_out_valid", s_if.out_valid, 0);
    accept_beat(8'hE2, 1'b1, 4'h0);
    check("s6_next_sel", sel, 0);
    s_if.in_valid = 1'b0;

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 60 == 0) chan_en = 4'($urandom_range(0, 15));
      s_if.in_valid  = ($urandom_range(0, 3) != 0);
      s_if.in_data   = 8'($urandom);
      s_if.in_last   = ($urandom_range(0, 2) == 0);
      s_if.out_ready = 4'($urandom);
      for (int i = 0; i < 4; i++) credit_ret[i] = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n         = 1'b1;
    credit_ret    = 4'h0;
    s_if.in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
